// File: rtl/sram_port_arb.sv
// Shares one SRAM port between two round-robin clients and the BIST engine (SRAM_ARB_FIXED_PRIO_EN: C0 always wins).
// Latency: grant comb, SRAM command 1 cycle after grant, read data RD_LAT cycles after command.
// Backpressure: an ungranted request just waits; BIST entry drains in-flight reads first.
module sram_port_arb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_wen0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_req1,
    input  logic              i_wen1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic              i_bist_en,
    input  logic              i_bist_csn,
    input  logic              i_bist_wen,
    input  logic [ADDR_W-1:0] i_bist_addr,
    input  logic [DATA_W-1:0] i_bist_wdata,
    output logic              o_bist_owned,
    output logic              o_csn,
    output logic              o_wen,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rd_data
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_BIST  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_bist_owned;
    logic                r_cmd_vld;
    logic                r_cmd_id;
    logic                r_wen;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [RD_LAT-1:0]   r_tag_vld;
    logic [RD_LAT-1:0]   r_tag_id;

    logic w_grant_ok;
    logic w_gnt0;
    logic w_gnt1;
    logic w_bist;
    logic w_rd_issue;
    logic w_tags_pending;
    logic w_drain_done;
    logic w_ret_vld;
    logic w_ret_id;

    // Grants are gated by reset so every output reads 0 while reset is held.
    assign w_grant_ok = i_reset & (r_state == ST_ARB) & ~i_bist_en;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign w_gnt0 = w_grant_ok & i_req0;
    assign w_gnt1 = w_grant_ok & i_req1 & ~i_req0;
`else
    logic r_prio1;

    assign w_gnt0 = w_grant_ok & i_req0 & (~i_req1 | ~r_prio1);
    assign w_gnt1 = w_grant_ok & i_req1 & (~i_req0 | r_prio1);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_prio1 <= 1'b0;
        end else if (w_gnt0) begin
            r_prio1 <= 1'b1;
        end else if (w_gnt1) begin
            r_prio1 <= 1'b0;
        end
    end
`endif

    assign o_gnt0 = w_gnt0;
    assign o_gnt1 = w_gnt1;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cmd_vld <= 1'b0;
            r_cmd_id  <= 1'b0;
            r_wen     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_cmd_vld <= w_gnt0 | w_gnt1;
            if (w_gnt0) begin
                r_cmd_id <= 1'b0;
                r_wen    <= i_wen0;
                r_addr   <= i_addr0;
                r_wdata  <= i_wdata0;
            end else if (w_gnt1) begin
                r_cmd_id <= 1'b1;
                r_wen    <= i_wen1;
                r_addr   <= i_addr1;
                r_wdata  <= i_wdata1;
            end
        end
    end

    assign w_rd_issue = r_cmd_vld & ~r_wen;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_rd_issue;
            r_tag_id[0]  <= r_cmd_id;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    // The last stage returns this cycle, so it does not hold up the drain.
    always_comb begin
        w_tags_pending = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            w_tags_pending = w_tags_pending | r_tag_vld[i];
        end
    end

    assign w_drain_done = ~r_cmd_vld & ~w_tags_pending;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_ARB;
            r_bist_owned <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (i_bist_en) begin
                        r_state <= ST_DRAIN;
                    end
                    r_bist_owned <= 1'b0;
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state      <= i_bist_en ? ST_BIST : ST_ARB;
                        r_bist_owned <= i_bist_en;
                    end
                end
                ST_BIST: begin
                    if (!i_bist_en) begin
                        r_state      <= ST_ARB;
                        r_bist_owned <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_ARB;
                    r_bist_owned <= 1'b0;
                end
            endcase
        end
    end

    assign w_bist       = (r_state == ST_BIST);
    assign o_bist_owned = r_bist_owned;
    assign o_csn        = w_bist ? i_bist_csn   : r_cmd_vld;
    assign o_wen        = w_bist ? i_bist_wen   : (r_cmd_vld & r_wen);
    assign o_addr       = w_bist ? i_bist_addr  : r_addr;
    assign o_wdata      = w_bist ? i_bist_wdata : r_wdata;

    assign w_ret_vld = r_tag_vld[RD_LAT-1];
    assign w_ret_id  = r_tag_id[RD_LAT-1];
    assign o_rvalid0 = w_ret_vld & ~w_ret_id;
    assign o_rvalid1 = w_ret_vld & w_ret_id;
    assign o_rdata0  = o_rvalid0 ? i_rd_data : '0;
    assign o_rdata1  = o_rvalid1 ? i_rd_data : '0;

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb at default parameters (RD_LAT=1).
// Inputs change 1 ns after the rising edge, outputs are sampled 4 ns after it.
module tb_sram_port_arb;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_req0, i_wen0, i_req1, i_wen1;
    logic [7:0] i_addr0, i_addr1, i_bist_addr;
    logic [9:0] i_wdata0, i_wdata1, i_bist_wdata, i_rd_data;
    logic       i_bist_en, i_bist_csn, i_bist_wen;
    logic       o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_bist_owned, o_csn, o_wen;
    logic [9:0] o_rdata0, o_rdata1, o_wdata;
    logic [7:0] o_addr;

    int n_total = 0;
    int n_bad   = 0;

    sram_port_arb dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_req0(i_req0), .i_wen0(i_wen0), .i_addr0(i_addr0), .i_wdata0(i_wdata0),
        .i_req1(i_req1), .i_wen1(i_wen1), .i_addr1(i_addr1), .i_wdata1(i_wdata1),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
        .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
        .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .i_bist_en(i_bist_en), .i_bist_csn(i_bist_csn), .i_bist_wen(i_bist_wen),
        .i_bist_addr(i_bist_addr), .i_bist_wdata(i_bist_wdata),
        .o_bist_owned(o_bist_owned),
        .o_csn(o_csn), .o_wen(o_wen), .o_addr(o_addr), .o_wdata(o_wdata),
        .i_rd_data(i_rd_data)
    );

    always #5 i_clock = ~i_clock;

    task automatic next_cycle();
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_req0 = 0; i_wen0 = 0; i_addr0 = 0; i_wdata0 = 0;
        i_req1 = 0; i_wen1 = 0; i_addr1 = 0; i_wdata1 = 0;
        i_bist_en = 0; i_bist_csn = 0; i_bist_wen = 0; i_bist_addr = 0; i_bist_wdata = 0;
        i_rd_data = 0;
        repeat (3) @(posedge i_clock);
        #3;
        i_reset = 1'b1;
        next_cycle();
        #3;
        n_total++;
        if ({o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_bist_owned, o_csn, o_wen, o_addr, o_wdata, o_rdata0, o_rdata1} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got gnt=%b%b rv=%b%b own=%b csn=%b wen=%b addr=%h wdata=%h rd=%h/%h required all zero",
                     o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_bist_owned, o_csn, o_wen, o_addr, o_wdata, o_rdata0, o_rdata1);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        logic [7:0] exp_a;
        next_cycle();
        i_req0 = 1; i_wen0 = 0; i_addr0 = 8'h20;
        i_req1 = 1; i_wen1 = 0; i_addr1 = 8'h30;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            #3;
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            n_total++;
            if ({o_gnt0, o_gnt1} !== exp_g) begin
                n_bad++;
                $display("FAIL rr_grant[%0d] got=%b required=%b", k, {o_gnt0, o_gnt1}, exp_g);
            end
            if (k > 0) begin
                exp_a = (k % 2 == 1) ? 8'h20 : 8'h30;
                n_total++;
                if ({o_csn, o_wen, o_addr} !== {1'b1, 1'b0, exp_a}) begin
                    n_bad++;
                    $display("FAIL rr_cmd[%0d] got csn=%b wen=%b addr=%h required 1 0 %h", k, o_csn, o_wen, o_addr, exp_a);
                end
            end
        end
        next_cycle();
        i_req0 = 0; i_req1 = 0;
        #3;
        n_total++;
        if ({o_gnt0, o_gnt1, o_csn, o_addr} !== {2'b00, 1'b1, 8'h30}) begin
            n_bad++;
            $display("FAIL rr_last_cmd got gnt=%b%b csn=%b addr=%h required 00 1 30", o_gnt0, o_gnt1, o_csn, o_addr);
        end
        next_cycle();
        #3;
        n_total++;
        if ({o_csn, o_wen, o_addr} !== {1'b0, 1'b0, 8'h30}) begin
            n_bad++;
            $display("FAIL idle_hold got csn=%b wen=%b addr=%h required 0 0 30", o_csn, o_wen, o_addr);
        end
    endtask

    task automatic test_read_c0();
        next_cycle();
        i_req0 = 1; i_wen0 = 0; i_addr0 = 8'h10;
        #3;
        n_total++;
        if ({o_gnt0, o_gnt1, o_csn} !== 3'b100) begin
            n_bad++;
            $display("FAIL rd0_grant got gnt=%b%b csn=%b required 10 0", o_gnt0, o_gnt1, o_csn);
        end
        next_cycle();
        i_req0 = 0; i_rd_data = 10'h155;
        #3;
        n_total++;
        if ({o_csn, o_wen, o_addr, o_rvalid0} !== {1'b1, 1'b0, 8'h10, 1'b0}) begin
            n_bad++;
            $display("FAIL rd0_cmd got csn=%b wen=%b addr=%h rv0=%b required 1 0 10 0", o_csn, o_wen, o_addr, o_rvalid0);
        end
        next_cycle();
        #3;
        n_total++;
        if ({o_rvalid0, o_rdata0, o_rvalid1, o_rdata1} !== {1'b1, 10'h155, 1'b0, 10'h000}) begin
            n_bad++;
            $display("FAIL rd0_return got rv0=%b rd0=%h rv1=%b rd1=%h required 1 155 0 000", o_rvalid0, o_rdata0, o_rvalid1, o_rdata1);
        end
        next_cycle();
        #3;
        n_total++;
        if ({o_rvalid0, o_rdata0, o_csn} !== {1'b0, 10'h000, 1'b0}) begin
            n_bad++;
            $display("FAIL rd0_pulse_end got rv0=%b rd0=%h csn=%b required 0 000 0", o_rvalid0, o_rdata0, o_csn);
        end
    endtask

    task automatic test_write_read_c1();
        next_cycle();
        i_req1 = 1; i_wen1 = 1; i_addr1 = 8'hFF; i_wdata1 = 10'h3FF;
        #3;
        n_total++;
        if ({o_gnt0, o_gnt1} !== 2'b01) begin
            n_bad++;
            $display("FAIL wr1_grant got=%b%b required 01", o_gnt0, o_gnt1);
        end
        next_cycle();
        i_wen1 = 0; i_wdata1 = 10'h000;
        #3;
        n_total++;
        if ({o_gnt1, o_csn, o_wen, o_addr, o_wdata} !== {1'b1, 1'b1, 1'b1, 8'hFF, 10'h3FF}) begin
            n_bad++;
            $display("FAIL wr1_cmd got gnt1=%b csn=%b wen=%b addr=%h wdata=%h required 1 1 1 ff 3ff",
                     o_gnt1, o_csn, o_wen, o_addr, o_wdata);
        end
        next_cycle();
        i_req1 = 0; i_rd_data = 10'h2AA;
        #3;
        n_total++;
        if ({o_csn, o_wen, o_addr, o_rvalid0, o_rvalid1} !== {1'b1, 1'b0, 8'hFF, 2'b00}) begin
            n_bad++;
            $display("FAIL rd1_cmd got csn=%b wen=%b addr=%h rv=%b%b required 1 0 ff 00",
                     o_csn, o_wen, o_addr, o_rvalid0, o_rvalid1);
        end
        next_cycle();
        #3;
        n_total++;
        if ({o_rvalid1, o_rdata1, o_rvalid0, o_rdata0} !== {1'b1, 10'h2AA, 1'b0, 10'h000}) begin
            n_bad++;
            $display("FAIL rd1_return got rv1=%b rd1=%h rv0=%b rd0=%h required 1 2aa 0 000", o_rvalid1, o_rdata1, o_rvalid0, o_rdata0);
        end
    endtask

    task automatic test_bist_entry();
        logic [7:0] a;
        logic [9:0] wd;
        next_cycle();
        i_req0 = 1; i_wen0 = 0; i_addr0 = 8'h44;
        #3;
        n_total++;
        if (o_gnt0 !== 1'b1) begin
            n_bad++;
            $display("FAIL bist_pre_grant got gnt0=%b required 1", o_gnt0);
        end
        next_cycle();
        i_req0 = 0; i_bist_en = 1; i_rd_data = 10'h0AB;
        i_req1 = 1; i_wen1 = 0; i_addr1 = 8'h55;
        #3;
        n_total++;
        if ({o_gnt1, o_csn, o_addr, o_bist_owned} !== {1'b0, 1'b1, 8'h44, 1'b0}) begin
            n_bad++;
            $display("FAIL bist_suppress got gnt1=%b csn=%b addr=%h own=%b required 0 1 44 0", o_gnt1, o_csn, o_addr, o_bist_owned);
        end
        next_cycle();
        #3;
        n_total++;
        if ({o_rvalid0, o_rdata0, o_gnt1, o_bist_owned, o_csn} !== {1'b1, 10'h0AB, 3'b000}) begin
            n_bad++;
            $display("FAIL drain_return got rv0=%b rd0=%h gnt1=%b own=%b csn=%b required 1 0ab 0 0 0",
                     o_rvalid0, o_rdata0, o_gnt1, o_bist_owned, o_csn);
        end
        for (int i = 0; i < 256; i++) begin
            next_cycle();
            a  = 8'(i);
            wd = 10'(i * 3 + 1);
            i_bist_csn = 1; i_bist_wen = a[0]; i_bist_addr = a; i_bist_wdata = wd;
            #3;
            n_total++;
            if ({o_bist_owned, o_gnt1, o_csn, o_wen, o_addr, o_wdata} !== {1'b1, 1'b0, 1'b1, a[0], a, wd}) begin
                n_bad++;
                $display("FAIL bist_pass[%0d] got own=%b gnt1=%b csn=%b wen=%b addr=%h wdata=%h required 1 0 1 %b %h %h",
                         i, o_bist_owned, o_gnt1, o_csn, o_wen, o_addr, o_wdata, a[0], a, wd);
            end
        end
    endtask

    task automatic test_bist_exit();
        next_cycle();
        i_bist_en = 0; i_bist_csn = 1; i_bist_wen = 0; i_bist_addr = 8'h77;
        #3;
        n_total++;
        if ({o_bist_owned, o_gnt1, o_addr} !== {1'b1, 1'b0, 8'h77}) begin
            n_bad++;
            $display("FAIL bist_last got own=%b gnt1=%b addr=%h required 1 0 77", o_bist_owned, o_gnt1, o_addr);
        end
        next_cycle();
        i_bist_csn = 0;
        #3;
        n_total++;
        if ({o_bist_owned, o_gnt0, o_gnt1, o_csn, o_wen} !== 5'b00100) begin
            n_bad++;
            $display("FAIL bist_release got own=%b gnt=%b%b csn=%b wen=%b required 0 01 0 0",
                     o_bist_owned, o_gnt0, o_gnt1, o_csn, o_wen);
        end
        next_cycle();
        i_req1 = 0;
        #3;
        n_total++;
        if ({o_csn, o_wen, o_addr} !== {1'b1, 1'b0, 8'h55}) begin
            n_bad++;
            $display("FAIL post_bist_cmd got csn=%b wen=%b addr=%h required 1 0 55", o_csn, o_wen, o_addr);
        end
        next_cycle();
        #3;
        n_total++;
        if ({o_rvalid1, o_rdata1, o_rvalid0} !== {1'b1, 10'h0AB, 1'b0}) begin
            n_bad++;
            $display("FAIL post_bist_return got rv1=%b rd1=%h rv0=%b required 1 0ab 0", o_rvalid1, o_rdata1, o_rvalid0);
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        i_req0 = 1; i_wen0 = 0; i_addr0 = 8'h66; i_rd_data = 10'h155;
        #3;
        n_total++;
        if (o_gnt0 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_grant got gnt0=%b required 1", o_gnt0);
        end
        next_cycle();
        i_req0 = 0;
        #3;
        n_total++;
        if ({o_csn, o_addr} !== {1'b1, 8'h66}) begin
            n_bad++;
            $display("FAIL mid_cmd got csn=%b addr=%h required 1 66", o_csn, o_addr);
        end
        i_reset = 1'b0;
        #1;
        n_total++;
        if ({o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_bist_owned, o_csn, o_wen, o_addr, o_wdata, o_rdata0, o_rdata1} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs got csn=%b addr=%h rv=%b%b required all zero", o_csn, o_addr, o_rvalid0, o_rvalid1);
        end
        next_cycle();
        i_reset = 1'b1;
        #3;
        n_total++;
        if ({o_rvalid0, o_rvalid1, o_csn} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_no_return got rv=%b%b csn=%b required 00 0", o_rvalid0, o_rvalid1, o_csn);
        end
        next_cycle();
        i_req0 = 1; i_req1 = 1; i_addr0 = 8'h01; i_addr1 = 8'h02;
        #3;
        n_total++;
        if ({o_gnt0, o_gnt1, o_rvalid0, o_rvalid1} !== 4'b1000) begin
            n_bad++;
            $display("FAIL post_reset_tie got gnt=%b%b rv=%b%b required 10 00", o_gnt0, o_gnt1, o_rvalid0, o_rvalid1);
        end
        next_cycle();
        i_req0 = 0; i_req1 = 0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read_c0();
        test_write_read_c1();
        test_bist_entry();
        test_bist_exit();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arb.md
Name: sram_port_arb

Overview:
- Shares the single SRAM macro port between two functional clients (C0, C1) and the SRAM BIST engine.
- Functional clients are arbitrated round-robin. Each client has a req/gnt handshake and a tagged read-data return.
- When BIST is enabled, the arbiter drains in-flight traffic, then hands the port to the BIST engine as a combinational pass-through until BIST is released.
- Sits between the client logic / BIST engine and the SRAM macro wrapper.

Parameters:
- ADDR_W, 8, SRAM address width.
- DATA_W, 10, SRAM data width.
- RD_LAT, 1, SRAM read latency in cycles from the o_csn cycle to valid i_rd_data; legal range 1..4.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  reset, asynchronous, active-low
- i_req0 / i_req1  in  1  client access request (level)
- i_wen0 / i_wen1  in  1  1=write, 0=read
- i_addr0 / i_addr1  in  ADDR_W  client address
- i_wdata0 / i_wdata1  in  DATA_W  client write data
- o_gnt0 / o_gnt1  out  1  grant; request accepted this cycle
- o_rvalid0 / o_rvalid1  out  1  read data valid pulse
- o_rdata0 / o_rdata1  out  DATA_W  read data
- i_bist_en  in  1  BIST requests port ownership (level)
- i_bist_csn, i_bist_wen  in  1  BIST SRAM controls
- i_bist_addr  in  ADDR_W  BIST address
- i_bist_wdata  in  DATA_W  BIST write data
- o_bist_owned  out  1  BIST currently owns the port
- o_csn  out  1  SRAM chip select, 1 = access this cycle
- o_wen  out  1  SRAM write enable, 1 = write
- o_addr  out  ADDR_W  SRAM address
- o_wdata  out  DATA_W  SRAM write data
- i_rd_data  in  DATA_W  SRAM read data

Behaviour:
- Reset values:
  - All outputs 0.
  - State ARB.
  - Round-robin pointer favours C0.
  - Read-tag pipeline empty.
- States:
  - ARB: normal arbitration.
  - DRAIN: no new grants; wait for outstanding reads to return.
  - BIST: BIST owns the port.
- ARB:
  - At most one grant per cycle, combinational from req and pointer. o_gntX is asserted in the same cycle as i_reqX.
  - When both clients request, the client not granted last wins. The pointer updates only on a grant.
  - A single requester is always granted, regardless of pointer.
  - Granted command (wen, addr, wdata) is registered. Next cycle: o_csn=1 and o_wen/o_addr/o_wdata = the captured values.
  - With no grant, o_csn=0, o_wen=0, and addr/wdata hold their last values.
  - Throughput is one access per cycle; back-to-back grants are allowed.
- Read return:
  - Each read issued at cycle T (o_csn=1, o_wen=0) pushes a {valid, client-id} tag into an RD_LAT-deep shift register.
  - At T+RD_LAT, o_rvalidX pulses for 1 cycle for the owning client only, with o_rdataX = i_rd_data.
  - o_rdataX is 0 when o_rvalidX=0.
  - Writes produce no return.
- ARB -> DRAIN: i_bist_en=1 sampled in ARB. Grants are suppressed in the same cycle i_bist_en is seen.
- DRAIN -> BIST: when the command register is idle and the tag pipeline is empty. With RD_LAT=1 and a read just issued, DRAIN lasts 1 cycle.
- BIST state:
  - o_bist_owned=1.
  - o_csn/o_wen/o_addr/o_wdata = i_bist_* (combinational).
  - Client grants are held 0.
- BIST -> ARB: i_bist_en=0.
  - o_bist_owned drops the next cycle.
  - SRAM controls return to 0 in that cycle.
  - The pointer is preserved.
- DRAIN with i_bist_en dropped: return to ARB only after drain completes; BIST is never entered.
- Client-request rule: a request held across cycles without a grant is legal. A client must keep req/addr stable until granted.
- Asynchronous reset mid-operation:
  - Outstanding read tags are discarded; no rvalid is emitted afterwards.
  - o_csn drops immediately.
- Illegal state encoding: recover to ARB on the next clock.

Optional Feature:
- Macro SRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, C0 always wins over C1; the pointer logic is removed.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then C0 read addr 0x10 with SRAM returning 0x155 -> o_gnt0 at cycle 0; o_csn=1, o_addr=0x10, o_wen=0 at cycle 1; o_rvalid0=1, o_rdata0=0x155 at cycle 1+RD_LAT; o_rvalid1 stays 0.
- C0 and C1 both hold req for 4 cycles -> grant order C0,C1,C0,C1; four consecutive o_csn=1 cycles with matching addresses.
- C1 write 0x3FF to addr 0xFF, then C1 read addr 0xFF -> o_wen=1, o_wdata=0x3FF on the write cycle; read returns on o_rvalid1 only.
- C0 read issued, i_bist_en raised the same cycle as a C1 req -> C1 not granted; C0 data still returned; o_bist_owned=1 after the pipeline is empty; BIST addr 0x00..0xFF visible on o_addr.
- i_bist_en dropped in BIST, then C1 req -> o_bist_owned=0 next cycle; C1 granted that cycle.
- i_reset pulsed low while a read is outstanding -> all outputs 0 immediately; no o_rvalid afterwards; first post-reset tie grants C0.
